// File: rtl/key_event_fifo.sv
// PS/2 scan-code decoder feeding a first-word-fall-through FIFO of make codes.
// Define KEY_EVENT_TYPEMATIC_EN to enqueue typematic repeats of a held key.
module key_event_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    scan_code,
    input  logic          scan_code_ready,
    output logic [7:0]    out_code,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic          overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0]  CODE_BREAK = 8'hF0;
    localparam logic [7:0]  CODE_EXT   = 8'hE0;
    localparam logic [AW:0] L_FULL     = (AW+1)'(DEPTH);

    state_t          r_state;
    state_t          w_state_next;
    logic            r_rdy_q;
    logic [7:0]      r_last_make;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            r_overflow;

    logic            w_event;
    logic            w_make;
    logic            w_brk_clear;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_wr;

    // The rising edge of the receiver's ready level is the only event source.
    assign w_event = scan_code_ready & ~r_rdy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rdy_q     <= 1'b1;
            r_last_make <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_rdy_q <= scan_code_ready;
            if (w_make)
                r_last_make <= scan_code;
            else if (w_brk_clear)
                r_last_make <= 8'h00;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_make       = 1'b0;
        w_brk_clear  = 1'b0;
        if (w_event) begin
            case (r_state)
                IDLE: begin
                    if (scan_code == CODE_BREAK)
                        w_state_next = BRK;
                    else if (scan_code == CODE_EXT)
                        w_state_next = EXT;
                    else
                        w_make = 1'b1;
                end
                BRK: begin
                    w_state_next = IDLE;
                    w_brk_clear  = (scan_code == r_last_make);
                end
                EXT: begin
                    w_state_next = (scan_code == CODE_BREAK) ? EXT_BRK : IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

`ifdef KEY_EVENT_TYPEMATIC_EN
    assign w_push = w_make;
`else
    // A repeat of the key still held down is suppressed until its break code.
    assign w_push = w_make && !((r_last_make != 8'h00) && (scan_code == r_last_make));
`endif

    assign w_full = (r_count == L_FULL);
    assign w_pop  = out_valid & out_ready;
    // When full, a simultaneous pop frees the slot the push will occupy.
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= scan_code;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

    assign out_code  = r_mem[r_rptr];
    assign out_valid = (r_count != '0);
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule
